// File: rtl/factor_display_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module : factor_capture_pkg
// Brief  : Shared types and constants for the factor display capture block.
// Rev    : 1.0 - initial release
// ============================================================================
package factor_capture_pkg;

    localparam int FACTOR_W = 14;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        COLLECT = 2'd2
    } state_e;

    // Segment patterns {g,f,e,d,c,b,a} for hex digits 0..F.
    localparam logic [6:0] SEG_PATTERN [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage
`default_nettype wire

// File: rtl/factor_display_capture_seg7_encoder_inv.sv
`default_nettype none
// ============================================================================
// Module : seg7_encoder_inv
// Brief  : Maps a seven-segment pattern back to its hex digit plus valid flag.
// Rev    : 1.0 - initial release
// ============================================================================
module seg7_encoder_inv
    import factor_capture_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       valid_o,
    output logic [3:0] digit_o
);

    always_comb begin
        valid_o = 1'b0;
        digit_o = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_PATTERN[i]) begin
                valid_o = 1'b1;
                digit_o = 4'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/factor_display_capture.sv
`default_nettype none
// ============================================================================
// Module : factor_display_capture
// Brief  : Filters the seven-segment stream, decodes stable digits and
//          rebuilds the factor bitmap from each 1..factors..1 display sweep.
// Rev    : 1.0 - initial release
// ============================================================================
module factor_display_capture
    import factor_capture_pkg::*;
#(
    parameter int                CNT_W         = 24,
    parameter logic [CNT_W-1:0]  STABLE_CYCLES = 24'd500,
    parameter logic [CNT_W-1:0]  DIGIT_PERIOD  = 24'd1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          seg_in,
    input  logic [7:0]          number_in,
    output logic [3:0]          digit_out,
    output logic                digit_strobe,
    output logic [FACTOR_W-1:0] factors_out,
    output logic                capture_valid,
    output logic                busy,
    output logic                decode_err
);

    logic [6:0]          seg_q;
    logic [7:0]          num_q;
    logic [CNT_W-1:0]    stab_cnt_q, stab_cnt_d;
    logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic                held_q, held_d;
    state_e              state_q, state_d;
    logic [FACTOR_W-1:0] acc_q, acc_d;
    logic [3:0]          last_q, last_d;
    logic [3:0]          digit_q, digit_d;
    logic                strobe_q, strobe_d;
    logic [FACTOR_W-1:0] factors_q, factors_d;
    logic                cap_q, cap_d;
    logic                err_q, err_d;

    logic       w_same, w_num_chg, w_first, w_rehold, w_accept;
    logic       w_valid, w_digit_ok, w_bad;
    logic [3:0] w_digit;

    seg7_encoder_inv u_enc (
        .seg_i   (seg_q),
        .valid_o (w_valid),
        .digit_o (w_digit)
    );

    assign w_same    = (seg_in == seg_q);
    assign w_num_chg = (number_in != num_q);
    // held_q blocks re-acceptance of the same pattern until the hold period expires.
    assign w_first   = !held_q && (stab_cnt_q >= STABLE_CYCLES);
    assign w_rehold  = held_q && (hold_cnt_q == DIGIT_PERIOD - CNT_W'(1));
    assign w_accept  = (w_first || w_rehold) && !w_num_chg;

    assign w_digit_ok = w_accept && w_valid && (w_digit != 4'd0);
    assign w_bad      = w_accept && !(w_valid && (w_digit != 4'd0));

    always_comb begin
        stab_cnt_d = stab_cnt_q;
        hold_cnt_d = hold_cnt_q;
        held_d     = held_q;
        if (w_num_chg || !w_same) begin
            stab_cnt_d = '0;
            hold_cnt_d = '0;
            held_d     = 1'b0;
        end else begin
            if (stab_cnt_q != {CNT_W{1'b1}}) begin
                stab_cnt_d = stab_cnt_q + CNT_W'(1);
            end
            if (w_accept) begin
                held_d     = 1'b1;
                hold_cnt_d = '0;
            end else if (held_q) begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        last_d    = last_q;
        digit_d   = digit_q;
        strobe_d  = 1'b0;
        factors_d = factors_q;
        cap_d     = 1'b0;
        err_d     = err_q;
        if (w_num_chg) begin
            acc_d     = '0;
            factors_d = '0;
            state_d   = SYNC;
        end else begin
            if (w_digit_ok) begin
                digit_d  = w_digit;
                strobe_d = 1'b1;
            end
            if (w_bad) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: state_d = SYNC;
                    SYNC: begin
                        if (w_digit_ok && (w_digit == 4'd1)) begin
                            state_d = COLLECT;
                            acc_d   = '0;
                            last_d  = 4'd1;
                        end
                    end
                    COLLECT: begin
                        if (w_digit_ok) begin
                            if (w_digit == 4'd1) begin
                                factors_d = acc_q;
                                cap_d     = 1'b1;
                                acc_d     = '0;
                                last_d    = 4'd1;
                            end else if (w_digit > last_q) begin
                                acc_d  = acc_q | (FACTOR_W'(1) << (w_digit - 4'd2));
                                last_d = w_digit;
                            end else begin
                                err_d   = 1'b1;
                                state_d = SYNC;
                            end
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q      <= '0;
            num_q      <= '0;
            stab_cnt_q <= '0;
            hold_cnt_q <= '0;
            held_q     <= 1'b0;
            state_q    <= IDLE;
            acc_q      <= '0;
            last_q     <= '0;
            digit_q    <= '0;
            strobe_q   <= 1'b0;
            factors_q  <= '0;
            cap_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            seg_q      <= seg_in;
            num_q      <= number_in;
            stab_cnt_q <= stab_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            held_q     <= held_d;
            state_q    <= state_d;
            acc_q      <= acc_d;
            last_q     <= last_d;
            digit_q    <= digit_d;
            strobe_q   <= strobe_d;
            factors_q  <= factors_d;
            cap_q      <= cap_d;
            err_q      <= err_d;
        end
    end

    assign digit_out     = digit_q;
    assign digit_strobe  = strobe_q;
    assign factors_out   = factors_q;
    assign capture_valid = cap_q;
    assign busy          = (state_q != IDLE);
    assign decode_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_factor_display_capture.sv
`default_nettype none
// ============================================================================
// Module : tb_factor_display_capture
// Brief  : Self-checking bench: segment runs vs. a digit-sequence reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_factor_display_capture;

    localparam int ST = 500;
    localparam int DP = 1000;

    logic        clk;
    logic        reset;
    logic [6:0]  seg_in;
    logic [7:0]  number_in;
    logic [3:0]  digit_out;
    logic        digit_strobe;
    logic [13:0] factors_out;
    logic        capture_valid;
    logic        busy;
    logic        decode_err;

    factor_display_capture dut (
        .clk           (clk),
        .reset         (reset),
        .seg_in        (seg_in),
        .number_in     (number_in),
        .digit_out     (digit_out),
        .digit_strobe  (digit_strobe),
        .factors_out   (factors_out),
        .capture_valid (capture_valid),
        .busy          (busy),
        .decode_err    (decode_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int n_checks = 0;
    int n_fail   = 0;

    int exp_digits[$];
    int exp_caps[$];
    int got_digits[$];
    int got_caps[$];

    // Reference model: a display sweep is just a list of digits.
    bit m_err, m_collect;
    int m_last, m_acc, m_factors, m_num;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (digit_strobe)  got_digits.push_back(int'(digit_out));
            if (capture_valid) got_caps.push_back(int'(factors_out));
        end
    end

    function automatic int seg_to_digit(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (seg_tbl[i] == p) return i;
        return -1;
    endfunction

    task automatic model_accept(input logic [6:0] p);
        int d;
        d = seg_to_digit(p);
        if (d <= 0) begin
            m_err = 1; m_collect = 0;
        end else begin
            exp_digits.push_back(d);
            if (!m_collect) begin
                if (d == 1) begin m_collect = 1; m_acc = 0; m_last = 1; end
            end else if (d == 1) begin
                m_factors = m_acc; exp_caps.push_back(m_acc); m_acc = 0; m_last = 1;
            end else if (d > m_last) begin
                m_acc = m_acc | (1 << (d - 2)); m_last = d;
            end else begin
                m_err = 1; m_collect = 0;
            end
        end
    endtask

    task automatic set_num(input int v);
        number_in = 8'(v);
        if (v != m_num) begin
            m_collect = 0; m_acc = 0; m_factors = 0; m_num = v;
        end
    endtask

    // Hold one pattern for len cycles; a stable run yields its first digit after
    // ST+1 cycles and a repeat every DP cycles thereafter.
    task automatic run_seg(input logic [6:0] p, input int len);
        int n;
        seg_in = p;
        n = (len >= ST + 1) ? 1 + (len - ST - 1) / DP : 0;
        for (int k = 0; k < n; k++) model_accept(p);
        repeat (len) @(posedge clk);
        #1;
    endtask

    task automatic checkpoint(input string tag);
        int n;
        check_value({tag, "_nstrobe"}, got_digits.size(), exp_digits.size());
        n = (got_digits.size() < exp_digits.size()) ? got_digits.size() : exp_digits.size();
        for (int i = 0; i < n; i++)
            check_value($sformatf("%s_digit%0d", tag, i), got_digits[i], exp_digits[i]);
        check_value({tag, "_ncapture"}, got_caps.size(), exp_caps.size());
        n = (got_caps.size() < exp_caps.size()) ? got_caps.size() : exp_caps.size();
        for (int i = 0; i < n; i++)
            check_value($sformatf("%s_cap%0d", tag, i), got_caps[i], exp_caps[i]);
        check_value({tag, "_factors"}, factors_out, m_factors);
        check_value({tag, "_err"}, decode_err, m_err);
        got_digits.delete(); exp_digits.delete();
        got_caps.delete();   exp_caps.delete();
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        number_in = 8'd0;
        @(posedge clk);
        #1;
        check_value({tag, "_digit"},   digit_out, 0);
        check_value({tag, "_strobe"},  digit_strobe, 0);
        check_value({tag, "_factors"}, factors_out, 0);
        check_value({tag, "_cap"},     capture_valid, 0);
        check_value({tag, "_busy"},    busy, 0);
        check_value({tag, "_err"},     decode_err, 0);
        reset = 1'b0;
        m_err = 0; m_collect = 0; m_acc = 0; m_factors = 0; m_last = 0; m_num = 0;
        got_digits.delete(); exp_digits.delete();
        got_caps.delete();   exp_caps.delete();
    endtask

    task automatic random_sweep(input int idx);
        int nv, len, a;
        int divs[$];
        nv = $urandom_range(2, 200);
        for (int d = 2; d <= 15; d++) if (nv % d == 0) divs.push_back(d);
        while (divs.size() == 0) begin
            nv = nv + 1;
            for (int d = 2; d <= 15; d++) if (nv % d == 0) divs.push_back(d);
        end
        set_num(nv);
        run_seg(7'h7F, 800);
        run_seg(7'h06, $urandom_range(600, 1400));
        foreach (divs[i]) begin
            if ($urandom_range(0, 2) == 0) begin
                // Mid-digit glitch: short lead-in, one blank cycle, then the rest.
                len = $urandom_range(1000, 1400);
                a   = $urandom_range(50, 400);
                run_seg(seg_tbl[divs[i]], a);
                run_seg(7'h00, 1);
                run_seg(seg_tbl[divs[i]], len - a - 1);
            end else begin
                run_seg(seg_tbl[divs[i]], $urandom_range(600, 1400));
            end
        end
        run_seg(7'h06, $urandom_range(600, 1400));
        checkpoint($sformatf("rand%0d_n%0d", idx, nv));
    endtask

    initial begin
        reset = 1'b1;
        seg_in = 7'h7F;
        number_in = 8'd0;
        m_num = 0;
        repeat (3) @(posedge clk);
        #1;
        do_reset("reset");

        // number 12: 1,2,3,4,6,C,1
        set_num(12);
        run_seg(7'h7F, 800);
        run_seg(7'h06, 1000); run_seg(7'h5B, 1000); run_seg(7'h4F, 1000);
        run_seg(7'h66, 1000); run_seg(7'h7D, 1000); run_seg(7'h39, 1000);
        run_seg(7'h06, 1000);
        check_value("n12_busy", busy, 1);
        checkpoint("n12");

        // number 13: repeated 1,D,1 sweeps
        set_num(13);
        run_seg(7'h7F, 800);
        run_seg(7'h06, 1000);
        for (int s = 0; s < 3; s++) begin
            run_seg(7'h5E, 1000);
            run_seg(7'h06, 1000);
        end
        checkpoint("n13");

        // number 1: single digit held, re-accepted every period
        set_num(1);
        run_seg(7'h7F, 800);
        run_seg(7'h06, 5000);
        checkpoint("n1");

        // glitch and short excursion inside a 12 sweep
        set_num(12);
        run_seg(7'h7F, 800);
        run_seg(7'h06, 1000);
        run_seg(7'h5B, 700); run_seg(7'h7F, 1); run_seg(7'h5B, 299);
        run_seg(7'h4F, 400); run_seg(7'h5B, 400);
        run_seg(7'h4F, 1000); run_seg(7'h66, 1000); run_seg(7'h7D, 1000);
        run_seg(7'h39, 1000); run_seg(7'h06, 1000);
        checkpoint("glitch");

        for (int r = 0; r < 3; r++) random_sweep(r);

        // mid-sweep number change 12 -> 13
        set_num(12);
        run_seg(7'h7F, 800);
        run_seg(7'h06, 1000); run_seg(7'h5B, 1000); run_seg(7'h4F, 1000);
        set_num(13);
        run_seg(7'h5E, 1000);
        checkpoint("numchg");
        run_seg(7'h06, 1000); run_seg(7'h5E, 1000); run_seg(7'h06, 1000);
        checkpoint("numchg_sweep");

        // descending order, then an invalid stable pattern
        run_seg(7'h6D, 1000); run_seg(7'h4F, 1000);
        checkpoint("order_err");
        run_seg(7'h00, 600);
        checkpoint("blank_err");

        // reset mid-sweep, then recovery
        run_seg(7'h06, 1000); run_seg(7'h5B, 1000);
        checkpoint("pre_reset");
        do_reset("midreset");
        set_num(12);
        run_seg(7'h06, 1000); run_seg(7'h5B, 1000); run_seg(7'h4F, 1000);
        run_seg(7'h66, 1000); run_seg(7'h7D, 1000); run_seg(7'h39, 1000);
        run_seg(7'h06, 1000);
        checkpoint("recover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
